bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD up/down counter; successor to the team's single-digit decade counter.
- Cascades NUM_DIGITS mod-10 digits through a ripple-free, same-cycle carry/borrow chain.
- Adds parallel load with BCD sanitising, optional saturation instead of wrap, and a registered wrap pulse.
- Used as the event/timer front end in the multiplier and display datapaths.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); count width is 4*NUM_DIGITS.
- RESET_VALUE, 0, integer value loaded on reset; must be valid BCD (each nibble <= 9).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- counter_on  input  1  count enable.
- count_up  input  1  1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- data_in  input  4*NUM_DIGITS  load value, one BCD nibble per digit, LS digit in [3:0].
- sat_en  input  1  1 = saturate at boundary, 0 = wrap.
- count  output  4*NUM_DIGITS  current BCD value.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Clocking and reset:
  - Reset is clk, asynchronous, active-high.
  - On reset: count = RESET_VALUE, wrap = 0.
- Priority each rising edge: reset > load > count > hold.
- load:
  - count <= data_in, with per-digit sanitising: any nibble > 9 is loaded as 9.
  - wrap <= 0.
  - Load wins over counter_on in the same cycle.
- Up count (counter_on=1, count_up=1):
  - Digit 0 increments.
  - Digit k increments only when all lower digits are 9.
  - A digit at 9 that increments becomes 0.
- Down count (counter_on=1, count_up=0):
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
- Boundaries:
  - Up at all-9s with sat_en=0: becomes all-0, and wrap pulses high for exactly the next cycle.
  - Up at all-9s with sat_en=1: holds all-9s, wrap stays 0.
  - Down at all-0s with sat_en=0: becomes all-9s, wrap pulses.
  - Down at all-0s with sat_en=1: holds all-0s.
- tc = (count_up && count == all-9s) || (!count_up && count == 0). tc is not gated by counter_on and follows count_up combinationally.
- wrap is 0 in every cycle that does not follow a wrap event.
- counter_on=0 and load=0: count holds, wrap <= 0.
- Direction may change on any cycle; the new direction takes effect on that edge.
- Reset asserted mid-count returns to RESET_VALUE immediately, independent of clk.
- Internal counter state never holds a non-BCD nibble.

Optional Feature:
- Macro: BCD_UPDOWN_COUNTER_OVF_STICKY_EN.
- Defined: adds output ovf_sticky (1 bit).
  - Set on any wrap event.
  - Held until reset or load.
  - A load in the same cycle as a wrap event wins (clears).
  - Saturation hits also set it.
- Undefined: port absent, no extra flops.

Decomposition:
- Package bcd_pkg:
  - BCD_W = 4, BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - typedef bcd_digit_t (logic [3:0]).
  - function bcd_sanitise (nibble > 9 -> 9).
- Sub-module bcd_digit, instantiated NUM_DIGITS times via generate:
  - inputs: en, up, load, din.
  - outputs: q, at_max, at_min.
  - at_max/at_min feed the AND-chain carry/borrow enables of higher digits.
- Top level holds the chain, saturation logic, wrap/ovf registers and tc.

Test Plan (NUM_DIGITS=3):
- Reset: assert reset between edges -> count=000 immediately. Release, counter_on=1, up, 12 clocks -> count=012, wrap never 1.
- Up carry chain: load 099, up 1 clk -> 100. Load 999, sat_en=0, 1 clk -> 000, wrap=1 for one cycle only, tc was 1 while at 999.
- Down borrow: load 100, down 1 clk -> 099. Load 000, sat_en=0, 1 clk -> 999, wrap pulse. Same with sat_en=1 -> stays 000, wrap=0, tc=1.
- Load priority and sanitising: load=1, counter_on=1, data_in=0x7A5 -> count=795 (nibble A clamped to 9), no increment that cycle.
- Direction flip and hold: at 500 toggle count_up each cycle for 4 clks -> 501,500,501,500. counter_on=0 for 3 clks -> holds 500. tc=0 throughout.
- BCD_UPDOWN_COUNTER_OVF_STICKY_EN build:
  - wrap 999->000 -> ovf_sticky=1, stays 1 over 20 more counts.
  - load 123 -> ovf_sticky=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and load sanitiser for the BCD counter family.
package bcd_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble above 9 is clamped to 9 so a digit never holds a non-BCD code.
  function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One mod-10 BCD digit with load, up/down step and boundary flags.
// Boundary flags feed the carry/borrow AND chain built in the top level.
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RESET_DIGIT = BCD_MIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t din,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);
  bcd_digit_t r_q;

  // Digit register: load has priority over stepping; 9 wraps to 0 going up and 0 to 9 going down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_q <= RESET_DIGIT;
    else if (load)  r_q <= din;
    else if (en) begin
      if (up) r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
      else    r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);
  assign at_min = (r_q == BCD_MIN);
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with sanitising parallel load, optional
// saturation and a registered wrap pulse. Carry/borrow is a same-cycle AND
// chain of per-digit boundary flags, so all digits step on one edge.
// Optional: define BCD_UPDOWN_COUNTER_OVF_STICKY_EN to add the ovf_sticky output.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    counter_on,
  input  logic                    count_up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    sat_en,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
`ifdef BCD_UPDOWN_COUNTER_OVF_STICKY_EN
  output logic                    ovf_sticky,
`endif
  output logic                    wrap
);
  localparam logic [31:0] RV = 32'(RESET_VALUE);

  logic [NUM_DIGITS-1:0] w_at_max;
  logic [NUM_DIGITS-1:0] w_at_min;
  logic [NUM_DIGITS-1:0] w_en;
  logic [NUM_DIGITS:0]   w_up_chain;
  logic [NUM_DIGITS:0]   w_dn_chain;
  logic                  w_boundary;
  logic                  w_step;
  logic                  w_wrap_evt;
  logic                  r_wrap;

  // Chain position k is high when every digit below k sits at its boundary.
  assign w_up_chain[0] = 1'b1;
  assign w_dn_chain[0] = 1'b1;

  // At the terminal value for the current direction, saturation blocks the step entirely.
  assign w_boundary = count_up ? w_up_chain[NUM_DIGITS] : w_dn_chain[NUM_DIGITS];
  assign w_step     = counter_on & ~load & ~(sat_en & w_boundary);
  assign w_wrap_evt = w_step & w_boundary;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign w_up_chain[k+1] = w_up_chain[k] & w_at_max[k];
    assign w_dn_chain[k+1] = w_dn_chain[k] & w_at_min[k];
    assign w_en[k]         = w_step & (count_up ? w_up_chain[k] : w_dn_chain[k]);

    bcd_digit #(.RESET_DIGIT(RV[4*k +: 4])) u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (w_en[k]),
      .up    (count_up),
      .load  (load),
      .din   (bcd_sanitise(data_in[4*k +: 4])),
      .q     (count[4*k +: 4]),
      .at_max(w_at_max[k]),
      .at_min(w_at_min[k])
    );
  end

  // Wrap pulse: high only in the cycle after a wrap-around step; load and hold clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= w_wrap_evt;
  end

  assign wrap = r_wrap;
  assign tc   = w_boundary;

`ifdef BCD_UPDOWN_COUNTER_OVF_STICKY_EN
  logic w_sat_hit;
  logic r_ovf_sticky;

  assign w_sat_hit = counter_on & ~load & sat_en & w_boundary;

  // Sticky overflow: set by wrap or saturation hit, cleared only by load or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_ovf_sticky <= 1'b0;
    else if (load)                    r_ovf_sticky <= 1'b0;
    else if (w_wrap_evt || w_sat_hit) r_ovf_sticky <= 1'b1;
  end

  assign ovf_sticky = r_ovf_sticky;
`endif
endmodule
